player_move_input: RTL
======================

// Module: player_move_input
// PURPOSE
// - Player-side front end that produces the move interface consumed by the tic-tac-toe game logic.
// - Turns raw push buttons into a 9-cell cursor and a one-cycle move strobe plus a 4-bit cell index.
// - Rejects a confirm on an occupied cell, using board state fed back from the game logic.
// - One instance per player.
// PARAMETERS
// - DEB_CYCLES  4  consecutive stable cycles before a debounced level changes (>=1).
// - Counter width is $clog2(DEB_CYCLES+1).
// PORTS
// - clk          in   1   single clock; all logic is on its rising edge.
// - rst          in   1   synchronous, active-high reset.
// - turn_en      in   1   high while it is this player's turn (level).
// - btn_next     in   1   raw async button: cursor +1.
// - btn_prev     in   1   raw async button: cursor -1.
// - btn_confirm  in   1   raw async button: play the cell under the cursor.
// - board        in   18  board[2k+1:2k] = cell k; 00 empty, 01 player 1, 10 player 2.
// - pos          out  4   cell index 0..8; valid while move=1.
// - move         out  1   one-cycle move strobe (drives j1/j2 of the game logic).
// - cursor       out  4   current highlighted cell 0..8 (for display).
// - reject       out  1   one-cycle pulse: confirm was on an occupied cell.
// BEHAVIOUR
// - Reset values: pos=0, move=0, cursor=0, reject=0.
//   - Reset also clears the synchronizers, debounce counters and edge registers; FSM goes to IDLE.
//   - Reset asserted mid-operation aborts any pending move; no strobe is emitted.
// - Input conditioning, each button:
//   - 2-flop synchronizer.
//   - Debounce: the debounced level takes the synced value after DEB_CYCLES equal consecutive samples.
//     Any differing sample restarts the count.
//   - Rising-edge detect on the debounced level gives a one-cycle event.
// - Latency: raw edge sampled at cycle 0 -> event at cycle 2+DEB_CYCLES -> move/reject/cursor update at cycle 3+DEB_CYCLES.
// - FSM states:
//   - IDLE: outputs quiet; events ignored. turn_en=1 -> SELECT.
//   - SELECT: act on events, then:
//     - turn_en=0 -> IDLE (cursor kept).
//     - confirm on an empty cell -> ISSUE.
//     - confirm on an occupied cell -> reject=1 for one cycle; stay in SELECT.
//   - ISSUE: move=1 and pos=cursor for exactly one cycle -> WAIT.
//   - WAIT: no events accepted. Leave to IDLE when turn_en=0, or to SELECT when the confirm debounced level is low and turn_en=1.
//     - This guarantees exactly one move per press.
// - Cursor arithmetic, mod 9:
//   - next: 8 -> 0; prev: 0 -> 8.
//   - Value is always in 0..8; never 9..15.
// - Event conflicts in the same cycle:
//   - next and prev together: both ignored.
//   - confirm with next/prev: confirm wins; cursor unchanged; the move uses the old cursor.
// - board is sampled combinationally in the cycle the confirm event is handled.
// - pos holds its last value after move drops.
// CONFIGURATION
// - SKIP_OCCUPIED_EN defined:
//   - next/prev advance to the nearest empty cell in that direction, with wrap-around.
//   - If every other cell is occupied, cursor stays put.
//   - On entry to SELECT, if the cursor cell is occupied, the cursor moves forward to the first empty cell.
// - SKIP_OCCUPIED_EN undefined: next/prev always step by exactly one cell; occupancy only matters for confirm/reject.
// TESTING
// - Reset with all buttons low -> cursor=0, move=0, reject=0, pos=0, FSM in IDLE.
// - turn_en=1, board=0, 9 clean next presses -> cursor 1..8 then 0.
//   - One prev from 0 -> 8.
//   - Each update lands 3+DEB_CYCLES cycles after its press.
// - turn_en=1, cursor=4, board=0, confirm held 20 cycles -> exactly one move pulse with pos=4; no second pulse until release and re-press.
// - board cell 4 = 01, cursor=4, confirm -> reject pulse one cycle, move stays 0.
//   - next, then confirm -> move with pos=5.
// - Glitchy confirm (high 2 cycles, low 1, repeated) with DEB_CYCLES=4 -> no move.
//   - next+prev rising together -> cursor unchanged.
// - rst pulsed while confirm is mid-debounce -> no move after reset.
//   - With SKIP_OCCUPIED_EN and cells 1,2 occupied, next from 0 -> cursor 3.

Source files
------------

// File: rtl/player_move_input.sv
// -----------------------------------------------------------------------------
// player_move_input
//
// Player-side front end for the tic-tac-toe game logic. Three raw push buttons
// are synchronized, debounced and edge-detected, then drive a small FSM that
// keeps a 0..8 cursor and emits a one-cycle move strobe with the cell index.
// A confirm on an occupied cell produces a one-cycle reject pulse instead.
//
// Build option:
//   SKIP_OCCUPIED_EN - when defined, next/prev jump to the nearest empty cell
//                      in that direction (with wrap-around), and entering
//                      SELECT on an occupied cell moves the cursor forward to
//                      the first empty cell. Undefined: plain +/-1 stepping.
//
// Parameters:
//   DEB_CYCLES   consecutive equal synced samples before a debounced level
//                changes (>=1).
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   turn_en      in   high while it is this player's turn
//   btn_next     in   raw button, cursor +1
//   btn_prev     in   raw button, cursor -1
//   btn_confirm  in   raw button, play the cell under the cursor
//   board        in   board[2k+1:2k] = cell k (00 empty, 01 P1, 10 P2)
//   pos          out  cell index of the move, valid while move=1, then held
//   move         out  one-cycle move strobe
//   cursor       out  highlighted cell 0..8
//   reject       out  one-cycle pulse on confirm of an occupied cell
// -----------------------------------------------------------------------------
module player_move_input #(
    parameter int DEB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        turn_en,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        btn_confirm,
    input  logic [17:0] board,
    output logic [3:0]  pos,
    output logic        move,
    output logic [3:0]  cursor,
    output logic        reject
);

    localparam int CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Cursor step helpers; the cursor never leaves 0..8.
    function automatic logic [3:0] inc9(input logic [3:0] c);
        if (c >= 4'd8) begin
            return 4'd0;
        end else begin
            return c + 4'd1;
        end
    endfunction

    function automatic logic [3:0] dec9(input logic [3:0] c);
        if (c == 4'd0) begin
            return 4'd8;
        end else begin
            return c - 4'd1;
        end
    endfunction

`ifdef SKIP_OCCUPIED_EN
    // Walk the ring from start in the given direction and return the first
    // empty cell. With incl=0 the start cell itself is never chosen, so a
    // full board (apart from start) leaves the cursor where it is.
    function automatic logic [3:0] find_empty(input logic [8:0] empty,
                                              input logic [3:0] start,
                                              input logic       fwd,
                                              input logic       incl);
        logic [3:0] c;
        logic [3:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        c     = incl ? start : (fwd ? inc9(start) : dec9(start));
        for (int k = 0; k < 9; k++) begin
            if (!found && empty[c] && (incl || (c != start))) begin
                res   = c;
                found = 1'b1;
            end
            c = fwd ? inc9(c) : dec9(c);
        end
        return res;
    endfunction
`endif

    // Button bit order: 0 = next, 1 = prev, 2 = confirm.
    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [2:0]       r_deb_q;
    logic [2:0]       r_evt;
    logic [CNT_W-1:0] r_cnt [3];

    state_t           r_state;
    logic [3:0]       r_cursor;
    logic [3:0]       r_pos;
    logic             r_move;
    logic             r_reject;

    logic [8:0]       w_empty;
    logic             w_evt_next;
    logic             w_evt_prev;
    logic             w_evt_confirm;
    logic [3:0]       w_next_cur;
    logic [3:0]       w_prev_cur;
    logic [3:0]       w_entry_cur;

    assign w_raw = {btn_confirm, btn_prev, btn_next};

    // Synchronize, debounce and rising-edge detect the three buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_deb   <= 3'b000;
            r_deb_q <= 3'b000;
            r_evt   <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            r_evt   <= r_deb & ~r_deb_q;
            // The count only runs while the synced value disagrees with the
            // debounced level; a sample back at the old level restarts it.
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= {CNT_W{1'b0}};
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= {CNT_W{1'b0}};
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Per-cell empty flags from the fed-back board.
    always_comb begin
        w_empty = 9'd0;
        for (int k = 0; k < 9; k++) begin
            w_empty[k] = (board[2*k +: 2] == 2'b00);
        end
    end

    // Resolve same-cycle event conflicts: confirm dominates, next+prev cancel.
    always_comb begin
        w_evt_confirm = r_evt[2];
        w_evt_next    = r_evt[0] & ~r_evt[1] & ~r_evt[2];
        w_evt_prev    = r_evt[1] & ~r_evt[0] & ~r_evt[2];
    end

    // Candidate cursor values for next, prev and SELECT entry.
    always_comb begin
`ifdef SKIP_OCCUPIED_EN
        w_next_cur  = find_empty(w_empty, r_cursor, 1'b1, 1'b0);
        w_prev_cur  = find_empty(w_empty, r_cursor, 1'b0, 1'b0);
        w_entry_cur = find_empty(w_empty, r_cursor, 1'b1, 1'b1);
`else
        w_next_cur  = inc9(r_cursor);
        w_prev_cur  = dec9(r_cursor);
        w_entry_cur = r_cursor;
`endif
    end

    // Move FSM with registered cursor, strobe and reject outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cursor <= 4'd0;
            r_pos    <= 4'd0;
            r_move   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_move   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (turn_en) begin
                        r_state  <= ST_SELECT;
                        r_cursor <= w_entry_cur;
                    end
                end
                ST_SELECT: begin
                    if (w_evt_confirm && turn_en) begin
                        if (w_empty[r_cursor]) begin
                            // Strobe is raised on the transition so it is
                            // high for exactly the one cycle spent in ISSUE.
                            r_state <= ST_ISSUE;
                            r_move  <= 1'b1;
                            r_pos   <= r_cursor;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end else if (w_evt_next) begin
                        r_cursor <= w_next_cur;
                    end else if (w_evt_prev) begin
                        r_cursor <= w_prev_cur;
                    end
                    if (!turn_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Hold here until confirm is released so one press can
                    // only ever produce one move.
                    if (!turn_en) begin
                        r_state <= ST_IDLE;
                    end else if (!r_deb[2]) begin
                        r_state  <= ST_SELECT;
                        r_cursor <= w_entry_cur;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pos    = r_pos;
    assign move   = r_move;
    assign cursor = r_cursor;
    assign reject = r_reject;

endmodule
